uart_byte_tx: RTL and testbench

- UART transmitter that serialises one 8-bit byte per request onto a single line, idle-high.
- Frame: 1 start bit (low), 8 data bits LSB first, optional parity bit, 1 stop bit (high).
- Timing comes from an internal bit-period counter, so the block needs no external baud tick.
- Sits between the host-side byte source (command/loopback logic) and the board RS-232 TX pin; it is the transmit counterpart of the UART receive path.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_bit_timer.sv | 18 +
 rtl/uart_byte_tx.sv | 100 ++++++++++
 tb/tb_uart_byte_tx.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, parity modes and defaults for the UART transmit path
package uart_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
  localparam int DEF_CLKS_PER_BIT = 434;
  function automatic logic par_bit(input int mode, input logic [7:0] d);
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter, pulses bit_end on the last cycle of each bit
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_end
);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  logic [15:0] cnt;
  assign bit_end = run && (cnt == LAST);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (run && !bit_end) ? cnt + 16'd1 : '0;
endmodule

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 / 8O1 / 8E1 byte serialiser with registered idle-high line
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PARITY = PAR_NONE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       rs232_tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam logic USE_PAR = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
  state_t state, state_d;
  logic [7:0] shreg, shreg_d;
  logic [2:0] bit_idx, bit_idx_d;
  logic par, par_d, tx_d, busy_d, done_d, bit_end;
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk),
    .rst(rst),
    .run(state != S_IDLE),
    .bit_end(bit_end)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      shreg <= '0;
      bit_idx <= '0;
      par <= 1'b0;
      rs232_tx <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_d;
      shreg <= shreg_d;
      bit_idx <= bit_idx_d;
      par <= par_d;
      rs232_tx <= tx_d;
      tx_busy <= busy_d;
      tx_done <= done_d;
    end
  // the line value for the next bit is computed here so rs232_tx stays a pure flop output
  always_comb begin
    state_d = state;
    shreg_d = shreg;
    bit_idx_d = bit_idx;
    par_d = par;
    tx_d = rs232_tx;
    busy_d = tx_busy;
    done_d = 1'b0;
    case (state)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          shreg_d = tx_data;
          par_d = par_bit(PARITY, tx_data);
          busy_d = 1'b1;
          tx_d = 1'b0;
          state_d = S_START;
        end
      end
      S_START:
        if (bit_end) begin
          state_d = S_DATA;
          tx_d = shreg[0];
          bit_idx_d = '0;
        end
      S_DATA:
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_d = USE_PAR ? S_PARITY : S_STOP;
            tx_d = USE_PAR ? par : 1'b1;
          end else begin
            shreg_d = shreg >> 1;
            bit_idx_d = bit_idx + 3'd1;
            tx_d = shreg[1];
          end
        end
      S_PARITY:
        if (bit_end) begin
          state_d = S_STOP;
          tx_d = 1'b1;
        end
      S_STOP:
        if (bit_end) begin
          state_d = S_IDLE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      default: begin
        state_d = S_IDLE;
        tx_d = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: scoreboard-driven frame checks across no/odd/even parity and the default bit period
module tb_uart_byte_tx;
  logic clk = 1'b0;
  logic rst;
  logic start[4];
  logic [7:0] data[4];
  logic tx[4], busy[4], done[4];
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  typedef struct {
    int d;
    logic [7:0] b;
    int pbit;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  uart_byte_tx #(.CLKS_PER_BIT(8), .PARITY(0)) d0 (.clk(clk), .rst(rst), .tx_start(start[0]), .tx_data(data[0]), .rs232_tx(tx[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_byte_tx #(.CLKS_PER_BIT(8), .PARITY(1)) d1 (.clk(clk), .rst(rst), .tx_start(start[1]), .tx_data(data[1]), .rs232_tx(tx[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_byte_tx #(.CLKS_PER_BIT(8), .PARITY(2)) d2 (.clk(clk), .rst(rst), .tx_start(start[2]), .tx_data(data[2]), .rs232_tx(tx[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_byte_tx d3 (.clk(clk), .rst(rst), .tx_start(start[3]), .tx_data(data[3]), .rs232_tx(tx[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  task automatic chk(input string nm, input int d, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s dut%0d got %b expected %b at %0t", nm, d, a, e, $time);
    end
  endtask

  task automatic send(input int d, input logic [7:0] b);
    start[d] = 1'b1;
    data[d] = b;
    exp_q.push_back(b);
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_tx", d, tx[d], 1'b1);
      chk("idle_busy", d, busy[d], 1'b0);
      chk("idle_done", d, done[d], 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic expect_frame(input int d, input int n, input int pbit);
    logic [7:0] b;
    logic bits[11];
    int nb;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty dut%0d got 0 entries expected 1", d);
      b = 8'h00;
    end else b = exp_q.pop_front();
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i + 1] = b[i];
    nb = (pbit < 0) ? 10 : 11;
    if (pbit >= 0) bits[9] = pbit[0];
    bits[nb - 1] = 1'b1;
    for (int k = 0; k < nb; k++)
      for (int c = 0; c < n; c++) begin
        chk($sformatf("line_bit%0d_cyc%0d", k, c), d, tx[d], bits[k]);
        chk("busy_in_frame", d, busy[d], 1'b1);
        chk("done_in_frame", d, done[d], 1'b0);
        @(negedge clk);
      end
    chk("done_pulse", d, done[d], 1'b1);
    chk("busy_clear", d, busy[d], 1'b0);
    chk("line_idle_after", d, tx[d], 1'b1);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{0, 8'hA5, -1};
    vecs[1] = '{0, 8'hFF, -1};
    vecs[2] = '{1, 8'h07, 0};
    vecs[3] = '{2, 8'h07, 1};
    vecs[4] = '{1, 8'h00, 1};
    vecs[5] = '{2, 8'h00, 0};
    vecs[6] = '{1, 8'h80, 0};
    vecs[7] = '{2, 8'hFE, 1};
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b0;
      data[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("reset_tx", i, tx[i], 1'b1);
      chk("reset_busy", i, busy[i], 1'b0);
      chk("reset_done", i, done[i], 1'b0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 8'hA5);
    fork
      expect_frame(0, 8, -1);
      begin
        repeat (20) @(negedge clk);
        start[0] = 1'b1;
        data[0] = 8'h3C;
        @(negedge clk);
        start[0] = 1'b0;
      end
    join
    idle(0, 24);
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].d, vecs[i].b);
      data[vecs[i].d] = ~vecs[i].b;
      expect_frame(vecs[i].d, 8, vecs[i].pbit);
      idle(vecs[i].d, 3);
    end
    start[0] = 1'b1;
    data[0] = 8'h00;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    @(negedge clk);
    expect_frame(0, 8, -1);
    fork
      expect_frame(0, 8, -1);
      begin
        repeat (5) @(negedge clk);
        start[0] = 1'b0;
      end
    join
    idle(0, 3);
    send(0, 8'hC3);
    repeat (29) @(negedge clk);
    chk("line_low_before_reset", 0, tx[0], 1'b0);
    rst = 1'b0;
    #1;
    chk("async_reset_tx", 0, tx[0], 1'b1);
    chk("async_reset_busy", 0, busy[0], 1'b0);
    chk("async_reset_done", 0, done[0], 1'b0);
    void'(exp_q.pop_front());
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(0, 20);
    send(0, 8'h5A);
    expect_frame(0, 8, -1);
    idle(0, 3);
    send(3, 8'h55);
    expect_frame(3, 434, -1);
    idle(3, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
